// File: rtl/lz77_encoder_if.sv
// Stream bundle between the LZ77 encoder and its environment.
//
// Handshake rule for both streams: a transfer happens on a rising clock
// edge where valid and ready are both high. The producer keeps valid and
// its payload stable until that edge. The consumer may drive ready without
// waiting for valid.
//   input stream : in_valid/in_char (producer = master), in_ready (encoder)
//   output stream: out_valid/code_pos/code_len/chardata/finish (encoder),
//                  out_ready (master)
//
// Other signals:
//   encode    - constant mode flag driven by the encoder
//   dbg_state - encoder FSM state, exported for observation
//
// Modports:
//   master - environment side (drives the input stream and out_ready)
//   slave  - encoder side
interface lz77_encoder_if;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] code_pos;
  logic [2:0] code_len;
  logic [7:0] chardata;
  logic       encode;
  logic       finish;
  logic [2:0] dbg_state;

  modport master (
    output in_valid, in_char, out_ready,
    input  in_ready, out_valid, code_pos, code_len, chardata, encode, finish,
           dbg_state
  );

  modport slave (
    input  in_valid, in_char, out_ready,
    output in_ready, out_valid, code_pos, code_len, chardata, encode, finish,
           dbg_state
  );
endinterface

// File: rtl/lz77_encoder.sv
// Streaming LZ77 encoder: 9-entry search buffer (index 0 = newest char),
// 8-entry look-ahead buffer, matches of up to 7 chars. Emits
// (code_pos, code_len, chardata) triplets until the END_CHAR literal goes out.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - lz77_encoder_if.slave: input byte stream, output triplet stream,
//           encode flag, sticky finish flag, FSM debug state
//
// FSM: FILL -> SEARCH (9 cycles, one candidate per cycle) -> EMIT
//      -> SHIFT (code_len+1 cycles) -> FILL, or straight to SEARCH once the
//      terminator is already in the look-ahead. DONE after the final triplet.
module lz77_encoder #(
  parameter logic [7:0] END_CHAR = 8'h24
) (
  input logic          clk,
  input logic          reset,
  lz77_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_FILL   = 3'd0,
    S_SEARCH = 3'd1,
    S_EMIT   = 3'd2,
    S_SHIFT  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [7:0] search_buf [0:8];
  logic [8:0] search_vld;          // bit k: search_buf[k] holds a real char
  logic [7:0] la_buf [0:7];
  logic [3:0] la_count;
  logic       end_seen;
  logic [3:0] cand;                // candidate position under test
  logic [2:0] best_len;
  logic [3:0] best_pos;
  logic [3:0] shift_cnt;
  logic [3:0] code_pos_q;
  logic [2:0] code_len_q;
  logic [7:0] chardata_q;
  logic       finish_q;

  // Match length for the current candidate.
  logic [2:0] limit;
  logic [2:0] cand_len;
  logic [7:0] elem;
  logic       run;
  logic [2:0] final_len;
  logic [3:0] final_pos;

  always_comb begin
    limit    = (la_count >= 4'd8) ? 3'd7 :
               (la_count == 4'd0) ? 3'd0 : 3'(la_count - 4'd1);
    cand_len = '0;
    run      = search_vld[cand];
    elem     = '0;
    for (int i = 0; i < 7; i++) begin
      // Walking past the start of the search buffer continues into the
      // look-ahead, which lets a match overlap the chars being encoded.
      if (cand >= 4'(i)) elem = search_buf[cand - 4'(i)];
      else               elem = la_buf[3'(4'(i) - cand - 4'd1)];
      if (run && (3'(i) < limit) && (elem == la_buf[3'(i)])) cand_len = 3'(i + 1);
      else                                                   run = 1'b0;
    end
    // Strict compare: on a tie the earlier (smaller) position is kept.
    final_len = (cand_len > best_len) ? cand_len : best_len;
    final_pos = (cand_len > best_len) ? cand     : best_pos;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FILL;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_FILL:   if (bus.in_valid && (la_count == 4'd7 || bus.in_char == END_CHAR))
                  state_next = S_SEARCH;
      S_SEARCH: if (cand == 4'd8) state_next = S_EMIT;
      S_EMIT:   if (bus.out_ready) state_next = finish_q ? S_DONE : S_SHIFT;
      S_SHIFT:  if (shift_cnt == 4'd1) state_next = end_seen ? S_SEARCH : S_FILL;
      S_DONE:   state_next = S_DONE;
      default:  state_next = S_FILL;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.in_ready  = (state == S_FILL) && !reset;
    bus.out_valid = (state == S_EMIT);
    bus.encode    = 1'b1;
    bus.dbg_state = state;
    bus.code_pos  = code_pos_q;
    bus.code_len  = code_len_q;
    bus.chardata  = chardata_q;
    bus.finish    = finish_q;
  end

  // Datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 9; k++) search_buf[k] <= '0;
      for (int k = 0; k < 8; k++) la_buf[k] <= '0;
      search_vld <= '0;
      la_count   <= '0;
      end_seen   <= 1'b0;
      cand       <= '0;
      best_len   <= '0;
      best_pos   <= '0;
      shift_cnt  <= '0;
      code_pos_q <= '0;
      code_len_q <= '0;
      chardata_q <= '0;
      finish_q   <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          cand     <= '0;
          best_len <= '0;
          best_pos <= '0;
          if (bus.in_valid) begin
            la_buf[la_count[2:0]] <= bus.in_char;
            la_count              <= la_count + 4'd1;
            if (bus.in_char == END_CHAR) end_seen <= 1'b1;
          end
        end
        S_SEARCH: begin
          best_len <= final_len;
          best_pos <= final_pos;
          if (cand == 4'd8) begin
            cand       <= '0;
            code_pos_q <= final_pos;
            code_len_q <= final_len;
            chardata_q <= la_buf[final_len];
            if (la_buf[final_len] == END_CHAR) finish_q <= 1'b1;
          end else begin
            cand <= cand + 4'd1;
          end
        end
        S_EMIT: begin
          if (bus.out_ready) shift_cnt <= {1'b0, code_len_q} + 4'd1;
        end
        S_SHIFT: begin
          cand          <= '0;
          best_len      <= '0;
          best_pos      <= '0;
          search_buf[0] <= la_buf[0];
          for (int k = 1; k < 9; k++) search_buf[k] <= search_buf[k-1];
          search_vld    <= {search_vld[7:0], 1'b1};
          for (int k = 0; k < 7; k++) la_buf[k] <= la_buf[k+1];
          la_buf[7]     <= '0;
          la_count      <= la_count - 4'd1;
          shift_cnt     <= shift_cnt - 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lz77_encoder.sv
module tb_lz77_encoder;
  localparam logic [7:0] END_CHAR = 8'h24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lz77_encoder_if bus ();

  lz77_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int          checks    = 0;
  int          failures  = 0;
  logic [14:0] exp_q[$];            // {code_pos, code_len, chardata}
  int          tri_idx   = 0;
  int          stall_idx = -1;
  int          stall_left = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] trip(input int pos, input int len, input logic [7:0] c);
    return {4'(pos), 3'(len), c};
  endfunction

  // ---------------- output monitor / scoreboard ----------------
  initial begin : monitor
    logic [14:0] exp_t;
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_triplet", {17'd0, bus.code_pos, bus.code_len, bus.chardata}, 32'h7fff);
          bus.out_ready = 1'b1;
        end else if (tri_idx == stall_idx && stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
          check("stall_hold", {bus.code_pos, bus.code_len, bus.chardata, bus.in_ready},
                {exp_q[0], 1'b0});
        end else begin
          bus.out_ready = 1'b1;
          exp_t = exp_q.pop_front();
          check($sformatf("triplet%0d", tri_idx),
                {bus.code_pos, bus.code_len, bus.chardata}, exp_t);
          check($sformatf("finish%0d", tri_idx), bus.finish, exp_t[7:0] == END_CHAR);
          tri_idx++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_char  = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    tri_idx      = 0;
    stall_idx    = -1;
    stall_left   = 0;
    bus.out_ready = 1'b1;
    reset        = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] c);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 300) begin
        check("input_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      if (gaps) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({"drain_", tag}, exp_q.size(), 0);
  endtask

  // After the final triplet: idle, sticky finish, no further bytes accepted.
  task automatic check_done(input string tag);
    bus.in_valid = 1'b1;
    bus.in_char  = 8'h61;
    repeat (6) begin
      @(negedge clk);
      check({"done_", tag}, {bus.in_ready, bus.out_valid, bus.finish}, 3'b001);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int n;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_char   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {bus.out_valid, bus.code_pos, bus.code_len, bus.chardata, bus.finish,
           bus.in_ready, bus.encode},
          {1'b0, 4'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1});
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", bus.in_ready, 1'b1);

    // 1: "abababab$" with first-triplet latency
    exp_q.push_back(trip(0, 0, "a"));
    exp_q.push_back(trip(0, 0, "b"));
    exp_q.push_back(trip(1, 6, END_CHAR));
    send_str("abababab", 1'b0);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) break;
    end
    check("first_latency", n, 10);
    send_str("$", 1'b0);
    wait_drain("abab");
    check_done("abab");

    // 2: run of 'a' exercising the length cap and the la_count-1 limit
    apply_reset();
    exp_q.push_back(trip(0, 0, "a"));
    exp_q.push_back(trip(0, 7, "a"));
    exp_q.push_back(trip(0, 2, END_CHAR));
    send_str("aaaaaaaaaaa$", 1'b0);
    wait_drain("aaaa");
    check_done("aaaa");

    // 3: tie between positions 1 and 3 resolves to 1
    apply_reset();
    exp_q.push_back(trip(0, 0, "a"));
    exp_q.push_back(trip(0, 0, "b"));
    exp_q.push_back(trip(1, 1, "c"));
    exp_q.push_back(trip(1, 1, END_CHAR));
    send_str("abaca$", 1'b0);
    wait_drain("abaca");
    check_done("abaca");

    // 4: backpressure on the second triplet
    apply_reset();
    stall_idx  = 1;
    stall_left = 5;
    exp_q.push_back(trip(0, 0, "a"));
    exp_q.push_back(trip(0, 0, "b"));
    exp_q.push_back(trip(1, 6, END_CHAR));
    send_str("abababab$", 1'b0);
    wait_drain("stall");
    check("stall_cycles_used", stall_left, 0);
    check_done("stall");

    // 5: gaps on the input stream
    apply_reset();
    exp_q.push_back(trip(0, 0, "a"));
    exp_q.push_back(trip(0, 0, "b"));
    exp_q.push_back(trip(1, 6, END_CHAR));
    send_str("abababab$", 1'b1);
    wait_drain("gaps");
    check_done("gaps");

    // 6: reset during the search of the third triplet, then a fresh stream
    apply_reset();
    exp_q.push_back(trip(0, 0, "a"));
    exp_q.push_back(trip(0, 0, "b"));
    exp_q.push_back(trip(1, 6, END_CHAR));
    send_str("abababab$", 1'b0);
    n = 0;
    while (tri_idx < 2 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("mid_two_triplets", tri_idx, 2);
    n = 0;
    while (bus.dbg_state != 3'd1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached_search", bus.dbg_state, 3'd1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mid_reset_outputs",
          {bus.out_valid, bus.code_pos, bus.code_len, bus.chardata, bus.finish, bus.in_ready},
          {1'b0, 4'd0, 3'd0, 8'd0, 1'b0, 1'b0});
    @(negedge clk);
    check("mid_reset_hold",
          {bus.out_valid, bus.code_pos, bus.code_len, bus.chardata, bus.finish, bus.in_ready},
          {1'b0, 4'd0, 3'd0, 8'd0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    tri_idx = 0;
    reset   = 1'b0;
    exp_q.push_back(trip(0, 0, "a"));
    exp_q.push_back(trip(0, 0, "b"));
    exp_q.push_back(trip(0, 0, END_CHAR));
    send_str("ab$", 1'b0);
    wait_drain("after_reset");
    check_done("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lz77_encoder.md
Name: lz77_encoder

Overview:
- Streaming LZ77 compressor; sits directly upstream of the LZ77 decoder.
- Consumes a byte stream terminated by '$' (8'h24) and emits (code_pos, code_len, chardata) triplets in the decoder's exact format.
- Search buffer: 9 entries (pos 0 = most recently encoded char). Look-ahead buffer: 8 entries. Maximum match length: 7.

Parameters:
- END_CHAR, 8'h24, terminator byte; the triplet carrying it ends the stream.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_char valid.
- in_char  input  8  input byte.
- in_ready  output  1  block accepts in_char this cycle.
- out_ready  input  1  downstream accepts the triplet.
- out_valid  output  1  triplet valid.
- code_pos  output  4  match start position in search buffer, 0..8.
- code_len  output  3  match length, 0..7.
- chardata  output  8  literal byte following the match.
- encode  output  1  constant 1 (encoder mode flag).
- finish  output  1  final triplet issued; sticky.

Behaviour:
- Reset (async): all search/look-ahead entries cleared and marked invalid; state FILL; la_count=0.
- Output reset values: out_valid=0, code_pos=0, code_len=0, chardata=0, finish=0; in_ready=0 while reset is high. encode=1 always.
- Handshakes: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
- FILL: in_ready=1. Each accepted byte is appended at look-ahead index la_count, then la_count++.
  - FILL ends when la_count==8 or the appended byte==END_CHAR. in_ready=0 from the following cycle.
- SEARCH: exactly 9 cycles, one candidate p per cycle, p=0..8.
  - Element E(p,i) = search[p-i] if p>=i, else lookahead[i-p-1] (overlap into look-ahead allowed).
  - len(p) = longest prefix i with E(p,i)==lookahead[i], capped at limit = min(7, la_count-1).
  - Invalid search[p] gives len(p)=0.
  - best is updated only if len(p) > best_len (strict), so ties resolve to the smallest p.
- EMIT: registered outputs.
  - code_pos = best_pos (0 when best_len==0); code_len = best_len; chardata = lookahead[best_len].
  - out_valid=1 on the first cycle after the 9th SEARCH cycle.
  - All outputs held stable until out_ready. Nothing is accepted in EMIT.
- SHIFT: best_len+1 cycles, one char per cycle.
  - lookahead[0] enters search[0]; search[k] moves to search[k+1]; search[8] is discarded; look-ahead shifts down; la_count--.
  - Then go to FILL. If END_CHAR was already received, skip FILL and go straight to SEARCH when la_count>0.
- Termination: when the emitted chardata==END_CHAR, finish=1 in the same cycle as out_valid.
  - After that transfer: state DONE, out_valid=0, in_ready=0, finish stays 1 until reset.
- Bytes after END_CHAR are never accepted (in_ready=0 once END_CHAR is appended).
- Reset mid-operation (any state) aborts immediately. Outputs take reset values, buffers become invalid, and the next stream starts fresh.
- Latency with no stalls: last FILL byte accepted at cycle t gives out_valid at t+10.

Test Plan:
- "abababab$", out_ready=1: triplets (0,0,'a'), (0,0,'b'), (1,6,'$'). finish=1 with the third; in_ready never reasserts.
- "aaaaaaaaaaa$" (11 'a'): (0,0,'a'), (0,7,'a'), (0,2,'$'). Checks the length cap of 7 and the la_count-1 limit.
- "abaca$": (0,0,'a'), (0,0,'b'), (1,1,'c'), (1,1,'$'). The final triplet checks the tie (pos1 vs pos3) resolving to pos 1.
- Backpressure: hold out_ready=0 for 5 cycles on the second triplet of "abababab$". out_valid and code fields stay stable; in_ready=0; the sequence is otherwise unchanged.
- Input gaps: toggle in_valid every other cycle during FILL. Triplets match the gap-free run, and no byte is dropped or duplicated.
- Assert reset during SEARCH of the third triplet, then send "ab$". Outputs are 0 during reset; then (0,0,'a'), (0,0,'b'), (0,0,'$'); finish=1 only at the end.
